// File: rtl/spi_reg_master.sv
// Mode-0 SPI controller: one two-byte frame (command, then data) per accepted start.
// Define SPI_REG_MASTER_ABORT_EN to add the abort input and the aborted flag.
module spi_reg_master #(
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned REG_W   = 8,
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned IBG     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              start,
    input  logic              rw,
    input  logic [1:0]        txn_width,
    input  logic [ADDR_W-1:0] addr,
    input  logic [REG_W-1:0]  wdata,
`ifdef SPI_REG_MASTER_ABORT_EN
    input  logic              abort,
    output logic              aborted,
`endif
    output logic              busy,
    output logic              done,
    output logic [REG_W-1:0]  rdata,
    output logic [REG_W-1:0]  status,
    output logic              spi_clk,
    output logic              spi_mosi,
    output logic              spi_cs_n,
    input  logic              spi_miso
);

    localparam int unsigned FRAME_W = 2 * REG_W;
    localparam int unsigned CNT_MAX = (CLK_DIV > IBG) ? CLK_DIV : IBG;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned BIT_W   = $clog2(REG_W + 1);

    typedef enum logic [2:0] {
        StIdle, StSetup, StShift0, StGap, StShift1, StHold, StCsIdle
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic                 sclk_q, sclk_d;
    logic                 cs_n_q, cs_n_d;
    logic [FRAME_W-1:0]   tx_q, tx_d;
    logic [FRAME_W-1:0]   rx_q, rx_d;
    logic [REG_W-1:0]     rdata_q, rdata_d;
    logic [REG_W-1:0]     status_q, status_d;
    logic                 wr_q, wr_d;
    logic                 aborted_q, aborted_d;
    logic [REG_W-1:0]     cmd;
    logic                 half_end;

    always_comb begin
        cmd                 = '0;
        cmd[REG_W-1]        = rw;
        cmd[REG_W-2 -: 2]   = txn_width;
        cmd[ADDR_W-1:0]     = addr;
    end

    assign half_end = (cnt_q == CNT_W'(CLK_DIV - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rdata_d   = rdata_q;
        status_d  = status_q;
        wr_d      = wr_q;
        aborted_d = aborted_q;
        done      = 1'b0;
        if (ena) begin
            cnt_d = cnt_q + 1'b1;
            unique case (state_q)
                StIdle: begin
                    cnt_d = '0;
                    if (start) begin
                        state_d   = StSetup;
                        cs_n_d    = 1'b0;
                        tx_d      = {cmd, rw ? wdata : {REG_W{1'b0}}};
                        wr_d      = rw;
                        aborted_d = 1'b0;
                    end
                end
                StSetup: begin
                    if (half_end) begin
                        state_d = StShift0;
                        cnt_d   = '0;
                        sclk_d  = 1'b1;
                        rx_d    = {rx_q[FRAME_W-2:0], spi_miso};
                    end
                end
                StShift0, StShift1: begin
                    if (half_end) begin
                        cnt_d = '0;
                        if (sclk_q) begin
                            sclk_d = 1'b0;
                            bit_d  = bit_q + 1'b1;
                            // Last bit of a byte keeps MOSI steady until the byte ends.
                            if (bit_q != BIT_W'(REG_W - 1)) begin
                                tx_d = tx_q << 1;
                            end
                        end else if (bit_q == BIT_W'(REG_W)) begin
                            bit_d = '0;
                            if (state_q == StShift0) begin
                                state_d = StGap;
                                tx_d    = tx_q << 1;
                            end else begin
                                state_d = StHold;
                            end
                        end else begin
                            sclk_d = 1'b1;
                            rx_d   = {rx_q[FRAME_W-2:0], spi_miso};
                        end
                    end
                end
                StGap: begin
                    if (cnt_q == CNT_W'(IBG - 1)) begin
                        state_d = StShift1;
                        cnt_d   = '0;
                        sclk_d  = 1'b1;
                        rx_d    = {rx_q[FRAME_W-2:0], spi_miso};
                    end
                end
                StHold: begin
                    if (half_end) begin
                        state_d = StCsIdle;
                        cnt_d   = '0;
                        cs_n_d  = 1'b1;
                    end
                end
                StCsIdle: begin
                    if (half_end) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        done    = 1'b1;
                        if (!aborted_q) begin
                            status_d = rx_q[FRAME_W-1 -: REG_W];
                            if (!wr_q) begin
                                rdata_d = rx_q[REG_W-1:0];
                            end
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
`ifdef SPI_REG_MASTER_ABORT_EN
            if (abort && (state_q inside {StSetup, StShift0, StGap, StShift1})) begin
                state_d   = StHold;
                cnt_d     = '0;
                bit_d     = '0;
                sclk_d    = 1'b0;
                aborted_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            tx_q      <= '0;
            rx_q      <= '0;
            rdata_q   <= '0;
            status_q  <= '0;
            wr_q      <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rdata_q   <= rdata_d;
            status_q  <= status_d;
            wr_q      <= wr_d;
            aborted_q <= aborted_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign rdata    = rdata_q;
    assign status   = status_q;
    assign spi_clk  = sclk_q;
    assign spi_cs_n = cs_n_q;
    assign spi_mosi = tx_q[FRAME_W-1];
`ifdef SPI_REG_MASTER_ABORT_EN
    assign aborted  = aborted_q;
`endif

endmodule
